hazard3_tick_gen: RTL and testbench

HAZARD3_TICK_GEN -- requirements
Module: hazard3_tick_gen

---
 rtl/hazard3_tick_gen.sv | 130 +++++++++++++
 tb/tb_hazard3_tick_gen.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard3_tick_gen.sv
// Timer tick generator: APB-programmable down-counter divider producing one-cycle
// tick pulses; the external NRZ tick source is compiled in by TICK_GEN_EXT_SYNC_EN.
module hazard3_tick_gen #(
    parameter logic [15:0] DIV_RESET = 16'd12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        tick
`ifdef TICK_GEN_EXT_SYNC_EN
    ,
    input  logic        ext_tick_nrz
`endif
);

    localparam logic [15:0] ADDR_CTRL  = 16'h0000;
    localparam logic [15:0] ADDR_DIV   = 16'h0004;
    localparam logic [15:0] ADDR_COUNT = 16'h0008;

    logic        bus_wr;
    logic        ctrl_wr;
    logic        div_wr;
    logic        en_q, en_d;
    logic        src_q, src_d;
    logic [15:0] div_q, div_d;
    logic [15:0] ctr_q, ctr_d;
    logic        tick_q, tick_d;
    logic [15:0] d_eff;
    logic [15:0] d_new;
    logic        ext_edge;
    logic        unused_pwdata;

    assign bus_wr  = psel & penable & pwrite;
    assign ctrl_wr = bus_wr & (paddr == ADDR_CTRL);
    assign div_wr  = bus_wr & (paddr == ADDR_DIV);

    assign d_eff = (div_q == '0) ? 16'd1 : div_q;
    assign d_new = (pwdata[15:0] == '0) ? 16'd1 : pwdata[15:0];

    assign en_d  = ctrl_wr ? pwdata[0] : en_q;
    assign div_d = div_wr ? pwdata[15:0] : div_q;

`ifdef TICK_GEN_EXT_SYNC_EN
    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    assign src_d = ctrl_wr ? pwdata[1] : src_q;

    // Synchroniser and history run regardless of EN/SRC so enabling never sees a stale edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            src_q   <= src_d;
            sync1_q <= ext_tick_nrz;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign ext_edge      = sync2_q ^ hist_q;
    assign unused_pwdata = ^pwdata[31:16];
`else
    assign src_q         = 1'b0;
    assign src_d         = 1'b0;
    assign ext_edge      = 1'b0;
    assign unused_pwdata = ^{pwdata[31:16], pwdata[1]};
`endif

    // A DIV write while dividing beats the counter's own reload; clearing EN freezes ctr
    always_comb begin
        ctr_d  = ctr_q;
        tick_d = 1'b0;
        if (en_d && src_d) begin
            tick_d = ext_edge;
        end
        if (div_wr && en_q && !src_q) begin
            ctr_d = d_new - 16'd1;
        end else if (ctrl_wr && en_d && !en_q) begin
            ctr_d = d_eff - 16'd1;
        end else if (en_q && en_d && !src_q && !src_d) begin
            if (ctr_q == '0) begin
                tick_d = 1'b1;
                ctr_d  = d_eff - 16'd1;
            end else begin
                ctr_d = ctr_q - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            div_q  <= DIV_RESET;
            ctr_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            en_q   <= en_d;
            div_q  <= div_d;
            ctr_q  <= ctr_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        prdata = '0;
        case (paddr)
            ADDR_CTRL:  prdata[1:0]  = {src_q, en_q};
            ADDR_DIV:   prdata[15:0] = div_q;
            ADDR_COUNT: prdata[15:0] = ctr_q;
            default:    prdata       = '0;
        endcase
    end

    assign tick    = tick_q;
    assign pready  = 1'b1;
    assign pslverr = 1'b0;

endmodule

// File: tb/tb_hazard3_tick_gen.sv
// Bench for hazard3_tick_gen: register table, directed multi-cycle sequences and
// random APB traffic against a cycle-count arithmetic model of the tick/COUNT behaviour.
module tb_hazard3_tick_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        tick;
`ifdef TICK_GEN_EXT_SYNC_EN
    logic        ext_tick_nrz = 1'b0;
    localparam bit HAS_EXT = 1'b1;
`else
    localparam bit HAS_EXT = 1'b0;
`endif

    hazard3_tick_gen #(.DIV_RESET(16'd12)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
`ifdef TICK_GEN_EXT_SYNC_EN
        .ext_tick_nrz(ext_tick_nrz),
`endif
        .tick        (tick)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: tick/COUNT derived from cycles elapsed since the last (re)load.
    int          cyc = 0;
    bit          m_en = 0;
    bit          m_src = 0;
    logic [15:0] m_div = 16'd12;
    int          m_anchor = 0;
    int          m_dv = 1;
    int          m_hold = 0;
    int          m_ext_t = -100;

    function automatic int deff(input logic [15:0] v);
        return (v == 16'd0) ? 1 : int'(v);
    endfunction

    function automatic int m_count();
        int k;
        if (m_en && !m_src) begin
            k = cyc - m_anchor;
            return m_dv - 1 - ((k - 1) % m_dv);
        end
        return m_hold;
    endfunction

    function automatic bit m_tick();
        int k;
        if (m_en && !m_src) begin
            k = cyc - m_anchor;
            return (k > m_dv) && (((k - 1) % m_dv) == 0);
        end
        if (m_en && m_src) return cyc == m_ext_t + 3;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [15:0] a);
        case (a)
            16'h0:   return {30'd0, m_src, m_en};
            16'h4:   return {16'd0, m_div};
            16'h8:   return 32'(m_count());
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input bit wr, input logic [15:0] a, input logic [31:0] d);
        int cur;
        bit new_en;
        bit new_src;
        cur = m_count();
        if (wr && a == 16'h0) begin
            new_en  = d[0];
            new_src = HAS_EXT ? d[1] : 1'b0;
            if (new_en && !m_en) begin
                if (new_src) m_hold = deff(m_div) - 1;
                else begin
                    m_anchor = cyc;
                    m_dv     = deff(m_div);
                end
            end else if (!new_en && m_en) begin
                m_hold = cur;
            end
            m_en  = new_en;
            m_src = new_src;
        end else if (wr && a == 16'h4) begin
            m_div = d[15:0];
            if (m_en && !m_src) begin
                m_anchor = cyc;
                m_dv     = deff(m_div);
            end
        end
        cyc++;
    endtask

    logic [31:0] last_rd;
    logic        last_tick;

    // One single-cycle APB access; starts and ends on a falling edge.
    task automatic access(input bit wr, input logic [15:0] a, input logic [31:0] d, input string name);
        psel = 1'b1; penable = 1'b1; pwrite = wr; paddr = a; pwdata = d;
        #1;
        last_rd = prdata;
        if (!wr) check({name, " prdata"}, prdata, m_read(a));
        @(posedge clk);
        model_edge(wr, a, d);
        @(negedge clk);
        last_tick = tick;
        check({name, " tick"}, {31'd0, tick}, {31'd0, m_tick()});
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic idle();
        access(1'b0, 16'h8, 32'd0, "idle");
    endtask

    task automatic do_reset();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset tick", {31'd0, tick}, 32'd0);
        paddr = 16'h8; #1; check("reset count", prdata, 32'd0);
        paddr = 16'h4; #1; check("reset div", prdata, 32'd12);
        paddr = 16'h0; #1; check("reset ctrl", prdata, 32'd0);
        m_en = 0; m_src = 0; m_div = 16'd12; m_hold = 0; m_ext_t = -100;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef TICK_GEN_EXT_SYNC_EN
    task automatic toggle_ext();
        ext_tick_nrz = ~ext_tick_nrz;
        m_ext_t = cyc;
    endtask
`endif

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] pat12;
        logic [7:0]  pat8;
        int          cnts[4];
        bit          tks[4];
        bit          any;
        bit          found;

        tbl[0]  = '{1'b0, 16'h0, 32'h0,         32'h0};
        tbl[1]  = '{1'b0, 16'h4, 32'h0,         32'd12};
        tbl[2]  = '{1'b0, 16'h8, 32'h0,         32'h0};
        tbl[3]  = '{1'b0, 16'hC, 32'h0,         32'h0};
        tbl[4]  = '{1'b1, 16'h4, 32'hABCD0005,  32'h0};
        tbl[5]  = '{1'b0, 16'h4, 32'h0,         32'h5};
        tbl[6]  = '{1'b1, 16'h8, 32'h0000FFFF,  32'h0};
        tbl[7]  = '{1'b0, 16'h8, 32'h0,         32'h0};
        tbl[8]  = '{1'b1, 16'hC, 32'h5,         32'h0};
        tbl[9]  = '{1'b0, 16'hC, 32'h0,         32'h0};
        tbl[10] = '{1'b1, 16'h0, 32'hFFFFFFFC,  32'h0};
        tbl[11] = '{1'b0, 16'h0, 32'h0,         32'h0};
        tbl[12] = '{1'b1, 16'h0, 32'h2,         32'h0};
        tbl[13] = '{1'b0, 16'h0, 32'h0,         HAS_EXT ? 32'h2 : 32'h0};
        tbl[14] = '{1'b1, 16'h0, 32'h0,         32'h0};
        tbl[15] = '{1'b0, 16'h4, 32'h0,         32'h5};

        @(negedge clk);
        do_reset();
        check("pready", {31'd0, pready}, 32'd1);
        check("pslverr", {31'd0, pslverr}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            access(tbl[i].wr, tbl[i].addr, tbl[i].data, $sformatf("tbl%0d", i));
            if (!tbl[i].wr) check($sformatf("tbl%0d table", i), last_rd, tbl[i].exp);
        end

        // DIV=4 then enable: pulses at T+5, T+9
        do_reset();
        access(1'b1, 16'h4, 32'd4, "d4 div");
        access(1'b1, 16'h0, 32'd1, "d4 en");
        pat12 = '0;
        pat12[0] = last_tick;
        for (int i = 1; i < 12; i++) begin
            idle();
            pat12[i] = last_tick;
        end
        check("div4 pattern", {20'd0, pat12}, 32'h110);

        // DIV=0 and DIV=1: constant tick, COUNT 0
        access(1'b1, 16'h4, 32'd0, "d0 div");
        check("d0 reload tick", {31'd0, last_tick}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            idle();
            check("d0 tick", {31'd0, last_tick}, 32'd1);
            check("d0 count", last_rd, 32'd0);
        end
        access(1'b1, 16'h4, 32'd1, "d1 div");
        for (int i = 0; i < 6; i++) begin
            idle();
            check("d1 tick", {31'd0, last_tick}, 32'd1);
            check("d1 count", last_rd, 32'd0);
        end

        // DIV change mid-period
        access(1'b1, 16'h4, 32'd10, "d10 div");
        for (int i = 0; i < 4; i++) idle();
        access(1'b1, 16'h4, 32'd3, "d3 div");
        check("d3 next tick", {31'd0, last_tick}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle();
            cnts[i] = int'(last_rd);
            tks[i]  = last_tick;
        end
        check("d3 count0", 32'(cnts[0]), 32'd2);
        check("d3 count1", 32'(cnts[1]), 32'd1);
        check("d3 count2", 32'(cnts[2]), 32'd0);
        check("d3 count3", 32'(cnts[3]), 32'd2);
        check("d3 ticks", {28'd0, tks[3], tks[2], tks[1], tks[0]}, 32'h4);

        // Clear EN while ctr = 5
        access(1'b1, 16'h4, 32'd10, "hold div");
        for (int i = 0; i < 4; i++) idle();
        access(1'b1, 16'h0, 32'd0, "hold clr");
        check("hold clr tick", {31'd0, last_tick}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            idle();
            check("hold count", last_rd, 32'd5);
            check("hold tick", {31'd0, last_tick}, 32'd0);
        end

        // Reset mid-period while tick is high
        access(1'b1, 16'h4, 32'd2, "mr div");
        access(1'b1, 16'h0, 32'd1, "mr en");
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            idle();
            found = last_tick;
        end
        check("mr tick before reset", {31'd0, found}, 32'd1);
        do_reset();
        any = 0;
        for (int i = 0; i < 15; i++) begin
            idle();
            any |= last_tick;
        end
        check("mr no tick after reset", {31'd0, any}, 32'd0);

        // CTRL=3
        access(1'b1, 16'h0, 32'd3, "c3 wr");
        access(1'b0, 16'h0, 32'd0, "c3 rd");
        check("c3 ctrl", last_rd, HAS_EXT ? 32'd3 : 32'd1);
        idle();
        check("c3 count", last_rd, HAS_EXT ? 32'd11 : 32'd10);
        for (int i = 0; i < 14; i++) idle();

`ifdef TICK_GEN_EXT_SYNC_EN
        // External source: each level change -> one tick after three edges
        do_reset();
        access(1'b1, 16'h0, 32'd3, "ext en");
        for (int i = 0; i < 4; i++) idle();
        for (int t = 0; t < 3; t++) begin
            toggle_ext();
            pat8 = '0;
            for (int i = 0; i < 8; i++) begin
                idle();
                pat8[i] = last_tick;
            end
            check($sformatf("ext pulse %0d", t), {24'd0, pat8}, 32'h4);
        end
        access(1'b1, 16'h0, 32'd0, "ext dis");
        toggle_ext();
        for (int i = 0; i < 6; i++) idle();
        access(1'b1, 16'h0, 32'd3, "ext reen");
        any = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            any |= last_tick;
        end
        check("ext no spurious", {31'd0, any}, 32'd0);
`endif

        // Random APB traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int unsigned op;
            logic [31:0] d;
            logic [15:0] a;
            op = $urandom_range(0, 9);
            d  = $urandom;
            if (op <= 1) begin
                if (HAS_EXT) d[1] = 1'b0;
                if ($urandom_range(0, 3) == 0) d[0] = 1'b0; else d[0] = 1'b1;
                access(1'b1, 16'h0, d, "rnd ctrl");
            end else if (op <= 3) begin
                d[15:0] = 16'($urandom_range(0, 6));
                access(1'b1, 16'h4, d, "rnd div");
            end else if (op == 4) begin
                case ($urandom_range(0, 3))
                    0: a = 16'h8;
                    1: a = 16'hC;
                    2: a = 16'h2;
                    default: a = 16'h10;
                endcase
                access(1'b1, a, d, "rnd other");
            end else begin
                a = 16'(4 * $urandom_range(0, 3));
                access(1'b0, a, 32'd0, "rnd read");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
